// File: rtl/booth_share_arbiter.sv
// Round-robin sharing of one sequential Booth multiplier between NREQ requesters.
// Optional abort on a stuck multiplier: define BOOTH_SHARE_ARBITER_TIMEOUT_EN (adds rsp_err).
module booth_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_result,
    output logic                  busy,
    output logic                  mul_load_n,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_result,
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
    output logic                  rsp_err,
`endif
    output logic [2:0]            state_dbg
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last, idx, pick_idx, cand;
    logic            pick_found;
    logic [WIDTH-1:0] a_sl [NREQ];
    logic [WIDTH-1:0] b_sl [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_sl[i] = a_bus[i*WIDTH +: WIDTH];
        assign b_sl[i] = b_bus[i*WIDTH +: WIDTH];
    end

`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          expired;
    assign expired = (tcnt == TW'(TIMEOUT - 1));
`endif

    // Handshake: req is a level held by the requester until its rsp_valid;
    // gnt pulses once when the request is accepted, rsp_valid pulses once with the product.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // SETTLE never looks at mul_done so a done left over from the last product is masked.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (pick_found) state_n = S_LOAD;
            S_LOAD:   state_n = S_SETTLE;
            S_SETTLE: state_n = S_RUN;
            S_RUN: begin
                if (mul_done) state_n = S_RESP;
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
                else if (expired) state_n = S_RESP;
`endif
            end
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= IW'(NREQ - 1);
            idx        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_result <= '0;
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
            tcnt       <= '0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        idx   <= pick_idx;
                        mul_a <= a_sl[pick_idx];
                        mul_b <= b_sl[pick_idx];
                    end
                end
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
                S_SETTLE: tcnt <= '0;
                S_RUN: begin
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                    end else if (expired) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
`else
                S_RUN: if (mul_done) rsp_result <= mul_result;
`endif
                S_RESP: last <= idx;
                default: ;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign mul_load_n = (state != S_LOAD);
    assign gnt        = (state == S_LOAD) ? (NREQ'(1) << idx) : '0;
    assign rsp_valid  = (state == S_RESP) ? (NREQ'(1) << idx) : '0;
    assign state_dbg  = state;

endmodule

// File: tb/tb_booth_share_arbiter.sv
// Bench for booth_share_arbiter: directed vector table, hand-written corner sequences,
// and randomized operations checked against a round-robin/product reference model.
module tb_booth_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int RW   = 2 * W;
    localparam int BW   = NREQ * W;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [BW-1:0]   a_bus, b_bus;
    logic [NREQ-1:0] gnt, rsp_valid;
    logic [RW-1:0]   rsp_result;
    logic            busy, mul_load_n;
    logic [W-1:0]    mul_a, mul_b;
    logic            mul_done;
    logic [RW-1:0]   mul_result;
    logic [2:0]      state_dbg;
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
    logic            rsp_err;
`endif

    always #5 clk = ~clk;

    booth_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy),
        .mul_load_n(mul_load_n), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
        .rsp_err(rsp_err),
`endif
        .state_dbg(state_dbg)
    );

    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp_q[$];

    function automatic logic [RW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [RW-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier model: product appears mul_lat cycles after the load strobe.
    int   mul_lat = 3;
    bit   stale_mode = 0;
    bit   never_done = 0;
    int   remaining = 0;
    int   stale_left = 0;
    bit   pend = 0;
    logic [W-1:0] ma, mb;

    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            stale_left = 0;
        end else if (!mul_load_n) begin
            ma = mul_a;
            mb = mul_b;
            remaining = mul_lat;
            pend = !never_done;
            if (stale_mode) stale_left = 2;
            else mul_done = 1'b0;
        end else begin
            if (stale_left > 0) begin
                stale_left--;
                if (stale_left == 0) mul_done = 1'b0;
            end
            if (pend) begin
                remaining--;
                if (remaining <= 0) begin
                    mul_done = 1'b1;
                    mul_result = prod(ma, mb);
                    pend = 0;
                end
            end
        end
    end

    task automatic run_op(input logic [NREQ-1:0] r, input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input int lat, output logic [NREQ-1:0] gv, output logic [NREQ-1:0] vv,
                          output logic [RW-1:0] res, output int loads, output int gcyc, output bit err_seen);
        gv = '0; vv = '0; res = '0; loads = 0; gcyc = 0; err_seen = 0;
        req = r; a_bus = a; b_bus = b; mul_lat = lat;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                gv = gnt;
                gcyc++;
                a_bus = BW'($urandom);
                b_bus = BW'($urandom);
            end
            if (!mul_load_n) loads++;
            if (rsp_valid != '0) begin
                vv = rsp_valid;
                res = rsp_result;
`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
                err_seen = rsp_err;
`endif
                req = '0;
                break;
            end
        end
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    typedef struct {
        logic [NREQ-1:0] r;
        logic [BW-1:0]   a, b;
        int              lat;
        int              exp_g;
        logic [RW-1:0]   exp_res;
    } vec_t;

    vec_t tv[15];

    initial begin
        logic [NREQ-1:0] gv, vv;
        logic [RW-1:0]   res;
        int              loads, gcyc, g, last_ref;
        bit              err_seen;
        logic [NREQ-1:0] r;
        logic [BW-1:0]   a, b;

        tv[0]  = '{4'b0001, 16'h0005, 16'h0003, 3, 0, 8'h0F};
        tv[1]  = '{4'b0010, 16'h0090, 16'h00B0, 2, 1, 8'h23};
        tv[2]  = '{4'b0100, 16'h0300, 16'h0A00, 5, 2, 8'hEE};
        tv[3]  = '{4'b1000, 16'h6000, 16'hF000, 1, 3, 8'hFA};
        tv[4]  = '{4'b0001, 16'h0000, 16'h0006, 2, 0, 8'h00};
        tv[5]  = '{4'b1111, 16'h4321, 16'h2F87, 4, 1, 8'hF0};
        tv[6]  = '{4'b1111, 16'h4321, 16'h2F87, 3, 2, 8'hFD};
        tv[7]  = '{4'b1111, 16'h4321, 16'h2F87, 3, 3, 8'h08};
        tv[8]  = '{4'b1111, 16'h4321, 16'h2F87, 2, 0, 8'h07};
        tv[9]  = '{4'b1111, 16'h4321, 16'h2F87, 5, 1, 8'hF0};
        tv[10] = '{4'b1010, 16'h4321, 16'h2F87, 1, 3, 8'h08};
        tv[11] = '{4'b1010, 16'h4321, 16'h2F87, 4, 1, 8'hF0};
        tv[12] = '{4'b0100, 16'h0800, 16'h0800, 1, 2, 8'h40};
        tv[13] = '{4'b0001, 16'h0008, 16'h0007, 6, 0, 8'hC8};
        tv[14] = '{4'b1000, 16'h7000, 16'h7000, 3, 3, 8'h31};

        mul_done = 1'b0; mul_result = '0;
        rst = 1'b1; req = '0; a_bus = '0; b_bus = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_busy", busy, 0);
        check("rst_load_n", mul_load_n, 1);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(tv[i].r, tv[i].a, tv[i].b, tv[i].lat, gv, vv, res, loads, gcyc, err_seen);
            check($sformatf("vec%0d_gnt", i), gv, oh(tv[i].exp_g));
            check($sformatf("vec%0d_gnt_len", i), gcyc, 1);
            check($sformatf("vec%0d_loads", i), loads, 1);
            check($sformatf("vec%0d_rsp_valid", i), vv, oh(tv[i].exp_g));
            check($sformatf("vec%0d_result", i), res, tv[i].exp_res);
        end

        // Stale done held through LOAD/SETTLE must not be taken as the new product.
        stale_mode = 1;
        run_op(4'b0010, 16'h0050, 16'h00D0, 4, gv, vv, res, loads, gcyc, err_seen);
        stale_mode = 0;
        check("stale_rsp_valid", vv, 4'b0010);
        check("stale_result", res, 8'hF1);

        // Reset while in RUN: nothing delivered, req[0] re-arbitrated afterwards.
        req = 4'b0001; a_bus = 16'h0002; b_bus = 16'h0003; mul_lat = 20;
        repeat (3) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gnt", gnt, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_result", rsp_result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_load_n", mul_load_n, 1);
        check("midrst_mul_a", mul_a, 0);
        check("midrst_mul_b", mul_b, 0);
        rst = 1'b0;
        run_op(4'b0001, 16'h0002, 16'h0003, 3, gv, vv, res, loads, gcyc, err_seen);
        check("regrant_gnt", gv, 4'b0001);
        check("regrant_loads", loads, 1);
        check("regrant_result", res, 8'h06);

        last_ref = 0;
        for (int n = 0; n < 40; n++) begin
            r = NREQ'($urandom_range(1, 15));
            a = BW'($urandom);
            b = BW'($urandom);
            g = rr_pick(last_ref, r);
            exp_q.push_back(prod(a[g*W +: W], b[g*W +: W]));
            run_op(r, a, b, $urandom_range(1, 6), gv, vv, res, loads, gcyc, err_seen);
            check($sformatf("rnd%0d_gnt", n), gv, oh(g));
            check($sformatf("rnd%0d_rsp_valid", n), vv, oh(g));
            check($sformatf("rnd%0d_loads", n), loads, 1);
            check($sformatf("rnd%0d_result", n), res, exp_q.pop_front());
            last_ref = g;
        end

`ifdef BOOTH_SHARE_ARBITER_TIMEOUT_EN
        never_done = 1;
        run_op(4'b0100, 16'h0300, 16'h0300, 3, gv, vv, res, loads, gcyc, err_seen);
        never_done = 0;
        check("to_rsp_valid", vv, 4'b0100);
        check("to_err", err_seen, 1);
        check("to_result", res, 0);
        run_op(4'b0100, 16'h0300, 16'h0300, 3, gv, vv, res, loads, gcyc, err_seen);
        check("after_to_err", err_seen, 0);
        check("after_to_result", res, 8'h09);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
